// File: rtl/fp_div_seq.sv
// Iterative minifloat divider, p = a / b. Restoring division on the
// significands yields one quotient bit per cycle. Format, class flags,
// saturation and exp_overflow side-band match fp_mul.
//
// state | meaning
// IDLE  | waiting for operands
// DIV   | restoring steps in progress, cnt_q steps remaining
// DONE  | result valid, held until out_ready
module fp_div_seq #(
  parameter int NEXP = 5,
  parameter int NSIG = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NEXP+NSIG:0]   a,
  input  logic [NEXP+NSIG:0]   b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NEXP+NSIG:0]   p,
  output logic [5:0]           pFlags,
  output logic [NEXP:0]        exp_overflow
);

  localparam int W    = NEXP + NSIG + 1;
  localparam int SW   = NSIG + 1;          // significand incl. hidden bit
  localparam int QW   = NSIG + 2;          // quotient / remainder width
  localparam int EW   = NEXP + 2;          // signed unbiased exponent width
  localparam int BIAS = (1 << (NEXP - 1)) - 1;
  localparam int EMAX = BIAS;
  localparam int EMIN = 1 - BIAS;
  localparam int CW   = $clog2(NSIG + 3);

  localparam logic signed [EW-1:0] EMAX_S = EW'(EMAX);
  localparam logic signed [EW-1:0] EMIN_S = EW'(EMIN);
  localparam logic signed [EW-1:0] UFL_S  = EW'(EMIN - NSIG);
  localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);

  localparam logic [5:0] F_INF  = 6'b000100;
  localparam logic [5:0] F_ZERO = 6'b001000;
  localparam logic [5:0] F_SUB  = 6'b010000;
  localparam logic [5:0] F_NORM = 6'b100000;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t                 state_q;
  logic                   out_valid_q;
  logic [W-1:0]           p_q;
  logic [5:0]             flags_q;
  logic [NEXP:0]          eovf_q;
  logic [CW-1:0]          cnt_q;
  logic [QW-1:0]          rem_q;
  logic [QW-1:0]          quo_q;
  logic [SW-1:0]          bsig_q;
  logic signed [EW-1:0]   texp_q;
  logic                   sign_q;

  logic [NEXP-1:0]        a_exp;
  logic [NEXP-1:0]        b_exp;
  logic                   in_sign;
  logic                   accept;
  logic                   in_special;
  logic signed [EW-1:0]   texp_init;
  logic [W-1:0]           spec_p;
  logic [5:0]             spec_flags;

  logic                   rem_ge;
  logic [QW-1:0]          rem_sub;
  logic [QW-1:0]          rem_d;
  logic [QW-1:0]          quo_d;

  logic [SW-1:0]          t_sig;
  logic signed [EW-1:0]   t2_exp;
  logic [EW-1:0]          sh_amt;
  logic [NSIG-1:0]        sub_sig;
  logic [NEXP-1:0]        biased;
  logic [NEXP:0]          ovf;
  logic [W-1:0]           fin_p;
  logic [5:0]             fin_flags;
  logic [NEXP:0]          fin_eovf;

  assign a_exp     = a[W-2:NSIG];
  assign b_exp     = b[W-2:NSIG];
  assign in_sign   = a[W-1] ^ b[W-1];
  assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign in_special = (a_exp == '0) | (b_exp == '0);
  assign texp_init = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp});

  assign out_valid    = out_valid_q;
  assign p            = p_q;
  assign pFlags       = flags_q;
  assign exp_overflow = eovf_q;

  // Special-case result: zero/subnormal dividend wins over zero/subnormal divisor.
  always_comb begin
    spec_p     = {in_sign, (W-1)'(1)};
    spec_flags = F_ZERO;
    if (a_exp != '0) begin
      spec_p     = {in_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
      spec_flags = F_INF;
    end
  end

  // One restoring step; the remainder always stays below 2*bsig so it fits QW bits.
  always_comb begin
    rem_ge  = rem_q >= {1'b0, bsig_q};
    rem_sub = rem_ge ? (rem_q - {1'b0, bsig_q}) : rem_q;
    rem_d   = QW'({rem_sub, 1'b0});
    quo_d   = {quo_q[QW-2:0], rem_ge};
  end

  // Normalise and classify the quotient produced by the final step.
  always_comb begin
    t_sig   = quo_d[QW-1] ? quo_d[QW-1:1] : quo_d[SW-1:0];
    t2_exp  = quo_d[QW-1] ? texp_q : (texp_q - EW'(1));
    sh_amt  = EMIN_S - t2_exp;
    sub_sig = NSIG'(t_sig >> sh_amt);
    biased  = NEXP'(t2_exp + BIAS_S);
    ovf     = (NEXP+1)'(t2_exp - EMAX_S);

    fin_p     = {sign_q, (W-1)'(1)};
    fin_flags = F_ZERO;
    fin_eovf  = '0;
    if (t2_exp < UFL_S) begin
      fin_p     = {sign_q, (W-1)'(1)};
      fin_flags = F_ZERO;
    end else if (t2_exp < EMIN_S) begin
      fin_p     = {sign_q, {NEXP{1'b0}}, sub_sig};
      fin_flags = F_SUB;
    end else if (t2_exp > EMAX_S) begin
      fin_p     = {sign_q, {NEXP{1'b1}}, t_sig[NSIG-1:0]};
      fin_flags = F_INF;
      fin_eovf  = ovf;
    end else begin
      fin_p     = {sign_q, biased, t_sig[NSIG-1:0]};
      fin_flags = F_NORM;
    end
  end

  // Control FSM and datapath registers; an accept overrides the state's own transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      p_q         <= '0;
      flags_q     <= '0;
      eovf_q      <= '0;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      bsig_q      <= '0;
      texp_q      <= '0;
      sign_q      <= 1'b0;
    end else begin
      case (state_q)
        S_DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            p_q         <= fin_p;
            flags_q     <= fin_flags;
            eovf_q      <= fin_eovf;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase

      if (accept) begin
        sign_q <= in_sign;
        if (in_special) begin
          state_q     <= S_DONE;
          out_valid_q <= 1'b1;
          p_q         <= spec_p;
          flags_q     <= spec_flags;
          eovf_q      <= '0;
        end else begin
          state_q     <= S_DIV;
          out_valid_q <= 1'b0;
          cnt_q       <= CW'(NSIG + 2);
          rem_q       <= QW'({1'b1, a[NSIG-1:0]});
          quo_q       <= '0;
          bsig_q      <= {1'b1, b[NSIG-1:0]};
          texp_q      <= texp_init;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq (NEXP=5, NSIG=10) with hand-computed results.
module tb_fp_div_seq;

  localparam logic [5:0] F_INF  = 6'b000100;
  localparam logic [5:0] F_ZERO = 6'b001000;
  localparam logic [5:0] F_SUB  = 6'b010000;
  localparam logic [5:0] F_NORM = 6'b100000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] p;
  logic [5:0]  pFlags;
  logic [5:0]  exp_overflow;

  int n_checks = 0;
  int n_fail = 0;

  fp_div_seq #(.NEXP(5), .NSIG(10)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .p(p),
    .pFlags(pFlags),
    .exp_overflow(exp_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Issue one operation, wait for the result, optionally stall, then consume it.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] ep, input logic [5:0] ef, input logic [5:0] eo,
                        input int elat, input int hold);
    int lat;
    @(negedge clk);
    a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
    check({tag, " in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~av; b = ~bv;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, elat);
    check({tag, " p"}, p, ep);
    check({tag, " flags"}, pFlags, ef);
    check({tag, " exp_ovf"}, exp_overflow, eo);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      check({tag, " held valid"}, out_valid, 1);
      check({tag, " held p"}, p, ep);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " consumed"}, out_valid, 0);
  endtask

  initial begin
    int lat;
    int seen;
    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid", out_valid, 0);
    check("rst p", p, 0);
    check("rst flags", pFlags, 0);
    check("rst exp_ovf", exp_overflow, 0);
    check("rst in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1'b1;

    run_op("3/1.5",      16'h4200, 16'h3E00, 16'h4000, F_NORM, 6'd0,  13, 5);
    run_op("1/3",        16'h3C00, 16'h4200, 16'h3555, F_NORM, 6'd0,  13, 0);
    run_op("-6/2",       16'hC600, 16'h4000, 16'hC200, F_NORM, 6'd0,  13, 0);
    run_op("1/0",        16'h3C00, 16'h0000, 16'h7C00, F_INF,  6'd0,  1,  2);
    run_op("0/2",        16'h0000, 16'h4000, 16'h0001, F_ZERO, 6'd0,  1,  0);
    run_op("0/0",        16'h0000, 16'h0000, 16'h0001, F_ZERO, 6'd0,  1,  0);
    run_op("-0/2",       16'h8000, 16'h4000, 16'h8001, F_ZERO, 6'd0,  1,  0);
    run_op("1/-sub",     16'h3C00, 16'h8001, 16'hFC00, F_INF,  6'd0,  1,  0);
    run_op("ovf",        16'h7800, 16'h0C00, 16'h7C00, F_INF,  6'd12, 13, 0);
    run_op("emax",       16'h7800, 16'h3C00, 16'h7800, F_NORM, 6'd0,  13, 0);
    run_op("emin",       16'h0400, 16'h3C00, 16'h0400, F_NORM, 6'd0,  13, 0);
    run_op("subnormal",  16'h0400, 16'h4000, 16'h0200, F_SUB,  6'd0,  13, 0);
    run_op("underflow",  16'h0400, 16'h7800, 16'h0001, F_ZERO, 6'd0,  13, 0);

    // Back-to-back: second operand accepted in the DONE cycle of the first.
    @(negedge clk);
    a = 16'h4200; b = 16'h3E00; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    a = 16'h3C00; b = 16'h4200;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b first latency", lat, 13);
    check("b2b first p", p, 16'h4000);
    check("b2b done in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b handoff out_valid", out_valid, 0);
    check("b2b handoff busy", in_ready, 0);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b second latency", lat, 13);
    check("b2b second p", p, 16'h3555);
    check("b2b second flags", pFlags, F_NORM);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b drained", out_valid, 0);
    check("b2b idle in_ready", in_ready, 1);

    // Reset in the middle of a division abandons it.
    @(negedge clk);
    a = 16'h4200; b = 16'h3E00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort out_valid", out_valid, 0);
    check("abort p", p, 0);
    check("abort flags", pFlags, 0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("abort no result", seen, 0);
    check("abort in_ready", in_ready, 1);
    run_op("after abort", 16'h4200, 16'h3E00, 16'h4000, F_NORM, 6'd0, 13, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
